// File: rtl/fifo_stream_reader_if.sv
// Bus bundle for the fifo stream reader.
// Carries the fifo read port (rd_en/dout/empty) and the outgoing valid/ready stream.
// The reader itself connects through the master modport. The modport that drives
// the fifo data and the downstream ready connects through slave.
interface fifo_stream_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_empty;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;

   modport master (
      output fifo_rd_en,
      input  fifo_dout,
      input  fifo_empty,
      output m_valid,
      input  m_ready,
      output m_data,
      output m_last
   );

   modport slave (
      input  fifo_rd_en,
      output fifo_dout,
      output fifo_empty,
      input  m_valid,
      output m_ready,
      input  m_data,
      input  m_last
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the synchronous fifo.
// Pops words through the fifo read port and presents them as a valid/ready stream.
// A 2-entry skid buffer absorbs the fifo's one-cycle read latency, so the adapter
// can sustain one beat per cycle. m_last marks the final beat of every PKT_LEN-beat packet.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int PKT_LEN    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   fifo_stream_reader_if.master bus
);

   // Beat index width. A single-beat packet still needs one bit so the vector is legal.
   localparam int              IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

   logic [1:0]            cnt_q, cnt_d;
   logic                  inflight_q, inflight_d;
   logic [IDX_W-1:0]      beat_idx_q, beat_idx_d;
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
   logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

   logic                  pop;
   logic                  rd_en;
   logic [2:0]            occ_after_pop;
   logic [1:0]            cnt_after_pop;

   // Handshake and read request: occupancy counts buffered and in-flight words minus this cycle's pop,
   // so a read is issued only when the skid buffer is guaranteed to have room for the returning word.
   always_comb begin
      pop           = (cnt_q != 2'd0) && bus.m_ready;
      occ_after_pop = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
      rd_en         = !rst && enable && !bus.fifo_empty && (occ_after_pop < 3'd2);
   end

   // Next-state: shift the buffer on a pop, then write any returning fifo word at the tail.
   always_comb begin
      buf0_d        = buf0_q;
      buf1_d        = buf1_q;
      beat_idx_d    = beat_idx_q;
      inflight_d    = rd_en;
      cnt_after_pop = cnt_q - {1'b0, pop};

      if (pop) begin
         buf0_d = buf1_q;
      end

      if (inflight_q) begin
         if (cnt_after_pop == 2'd0) begin
            buf0_d = bus.fifo_dout;
         end else begin
            buf1_d = bus.fifo_dout;
         end
      end

      cnt_d = cnt_after_pop + {1'b0, inflight_q};

      if (pop) begin
         if (beat_idx_q == LAST_IDX) begin
            beat_idx_d = '0;
         end else begin
            beat_idx_d = beat_idx_q + 1'b1;
         end
      end
   end

   // State registers with synchronous reset; a word still in flight at reset is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= 2'd0;
         inflight_q <= 1'b0;
         beat_idx_q <= '0;
         buf0_q     <= '0;
         buf1_q     <= '0;
      end else begin
         cnt_q      <= cnt_d;
         inflight_q <= inflight_d;
         beat_idx_q <= beat_idx_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = (cnt_q != 2'd0);
   assign bus.m_data     = buf0_q;
   assign bus.m_last     = (beat_idx_q == LAST_IDX);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader.
// A fifo model feeds the DUT. A background monitor compares every accepted beat
// against the sequence of words pushed into the fifo, and compares m_last against
// the beat count modulo PKT_LEN. Words the fifo handed out before a reset are
// treated as lost. Directed scenarios cover reset, latency, backpressure, enable
// and mid-packet reset. These are followed by a randomized soak and a final drain.
module tb_fifo_stream_reader;

   localparam int DW        = 8;
   localparam int PKT_LEN   = 4;
   localparam int MEM_DEPTH = 4096;

   logic clk = 1'b0;
   logic rst;
   logic enable;

   fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

   fifo_stream_reader #(
      .DATA_WIDTH (DW),
      .PKT_LEN    (PKT_LEN)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .bus    (bus)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Fifo model: the word store, plus counters of words pushed and words popped
   logic [DW-1:0] fifo_mem [MEM_DEPTH];
   int            pushed_cnt = 0;
   int            popped_cnt = 0;
   logic [DW-1:0] dout_r     = '0;
   int            rst_edges  = 0;

   assign bus.fifo_empty = (pushed_cnt == popped_cnt);
   assign bus.fifo_dout  = dout_r;

   // Reference model state, owned by the monitor
   int            exp_idx  = 0;
   int            beat_cnt = 0;
   logic          hold_pending = 1'b0;
   logic [DW-1:0] hold_data    = '0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pushWord(input logic [DW-1:0] w);
      fifo_mem[pushed_cnt % MEM_DEPTH] = w;
      pushed_cnt++;
   endtask

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) nextCycle();
   endtask

   task automatic applyStimulus();
      rst        = ($urandom_range(0, 199) == 0);
      enable     = ($urandom_range(0, 6) != 0);
      bus.m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 4) pushWord(DW'($urandom));
   endtask

   // Fifo behaviour: a pop on an edge presents the word during the next cycle.
   // Between pops the data lines carry random values.
   always @(posedge clk) begin
      rst_edges <= rst ? rst_edges + 1 : 0;
      if (bus.fifo_rd_en && !bus.fifo_empty) begin
         dout_r     <= fifo_mem[popped_cnt % MEM_DEPTH];
         popped_cnt <= popped_cnt + 1;
      end else begin
         dout_r <= DW'($urandom);
      end
   end

   // Monitor: sampled mid-cycle, and it sees exactly the values the next edge will act on
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
         if (rst_edges >= 1) begin
            checkOutput("rst_m_valid", 32'(bus.m_valid), 32'd0);
            checkOutput("rst_m_data", 32'(bus.m_data), 32'd0);
            checkOutput("rst_m_last", 32'(bus.m_last), 32'(PKT_LEN == 1));
         end
         exp_idx      = popped_cnt;
         beat_cnt     = 0;
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            checkOutput("hold_valid", 32'(bus.m_valid), 32'd1);
            checkOutput("hold_data", 32'(bus.m_data), 32'(hold_data));
         end
         if (bus.m_valid && bus.m_ready) begin
            checkOutput("beat_available", 32'(popped_cnt > exp_idx), 32'd1);
            checkOutput("beat_data", 32'(bus.m_data), 32'(fifo_mem[exp_idx % MEM_DEPTH]));
            checkOutput("beat_last", 32'(bus.m_last), 32'((beat_cnt % PKT_LEN) == PKT_LEN - 1));
            exp_idx++;
            beat_cnt++;
         end
         hold_pending = bus.m_valid && !bus.m_ready;
         hold_data    = bus.m_data;
      end
   end

   initial begin
      int base;
      int drain_cycles;

      rst         = 1'b1;
      enable      = 1'b0;
      bus.m_ready = 1'b0;

      // Reset held two cycles while the fifo already has data
      pushWord(8'd11);
      pushWord(8'd22);
      pushWord(8'd33);
      enable = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("t1_rd_en_in_rst", 32'(bus.fifo_rd_en), 32'd0);
      nextCycle();
      checkOutput("t1_rd_en_in_rst2", 32'(bus.fifo_rd_en), 32'd0);
      rst         = 1'b0;
      bus.m_ready = 1'b1;
      #1;
      checkOutput("t2_rd_en_c0", 32'(bus.fifo_rd_en), 32'd1);
      checkOutput("t2_valid_c0", 32'(bus.m_valid), 32'd0);
      nextCycle();
      checkOutput("t2_rd_en_c1", 32'(bus.fifo_rd_en), 32'd1);
      checkOutput("t2_valid_c1", 32'(bus.m_valid), 32'd0);
      nextCycle();
      checkOutput("t2_valid_c2", 32'(bus.m_valid), 32'd1);
      checkOutput("t2_data_c2", 32'(bus.m_data), 32'd11);
      checkOutput("t2_rd_en_c2", 32'(bus.fifo_rd_en), 32'd1);
      nextCycle();
      checkOutput("t2_data_c3", 32'(bus.m_data), 32'd22);
      checkOutput("t2_rd_en_empty", 32'(bus.fifo_rd_en), 32'd0);
      nextCycle();
      checkOutput("t2_data_c4", 32'(bus.m_data), 32'd33);
      checkOutput("t2_valid_c4", 32'(bus.m_valid), 32'd1);
      nextCycle();
      checkOutput("t2_valid_c5", 32'(bus.m_valid), 32'd0);

      // Backpressure: only two words fit in flight/buffer, and the head stays put
      bus.m_ready = 1'b0;
      base = popped_cnt;
      pushWord(8'd11);
      pushWord(8'd22);
      pushWord(8'd33);
      pushWord(8'd44);
      waitCycles(8);
      checkOutput("t3_two_pops", 32'(popped_cnt - base), 32'd2);
      checkOutput("t3_head_held", 32'(bus.m_data), 32'd11);
      bus.m_ready = 1'b1;
      #1;
      checkOutput("t3_out0", 32'(bus.m_data), 32'd11);
      nextCycle();
      checkOutput("t3_valid1", 32'(bus.m_valid), 32'd1);
      checkOutput("t3_out1", 32'(bus.m_data), 32'd22);
      nextCycle();
      checkOutput("t3_valid2", 32'(bus.m_valid), 32'd1);
      checkOutput("t3_out2", 32'(bus.m_data), 32'd33);
      nextCycle();
      checkOutput("t3_valid3", 32'(bus.m_valid), 32'd1);
      checkOutput("t3_out3", 32'(bus.m_data), 32'd44);
      nextCycle();
      checkOutput("t3_drained", 32'(bus.m_valid), 32'd0);

      // Enable dropped right after a pop: the in-flight word still arrives
      base = popped_cnt;
      for (int i = 0; i < 5; i++) pushWord(8'(8'h50 + i));
      #1;
      checkOutput("t5_rd_en_first", 32'(bus.fifo_rd_en), 32'd1);
      nextCycle();
      enable = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("t5_no_rd_en", 32'(bus.fifo_rd_en), 32'd0);
         nextCycle();
      end
      checkOutput("t5_one_pop", 32'(popped_cnt - base), 32'd1);
      checkOutput("t5_inflight_out", 32'(exp_idx - base), 32'd1);
      enable = 1'b1;
      #1;
      checkOutput("t5_resume", 32'(bus.fifo_rd_en), 32'd1);
      waitCycles(10);

      // Sustained throughput: one beat every cycle once the first word lands
      for (int i = 0; i < 20; i++) pushWord(8'(8'h80 + i));
      nextCycle();
      nextCycle();
      for (int i = 0; i < 20; i++) begin
         checkOutput("thru_valid", 32'(bus.m_valid), 32'd1);
         nextCycle();
      end
      waitCycles(4);

      // Packet marking from a fresh reset: 9 beats leaves beat index at 1
      rst = 1'b1;
      waitCycles(2);
      rst  = 1'b0;
      base = exp_idx;
      for (int i = 0; i < 9; i++) pushWord(8'(8'hA0 + i));
      waitCycles(14);
      checkOutput("t4_nine_beats", 32'(exp_idx - base), 32'd9);
      checkOutput("t4_last_after9", 32'(bus.m_last), 32'd0);

      // Mid-packet reset with a full buffer; packet count restarts afterwards
      bus.m_ready = 1'b0;
      for (int i = 0; i < 6; i++) pushWord(8'(8'hC0 + i));
      waitCycles(6);
      bus.m_ready = 1'b1;
      waitCycles(2);
      bus.m_ready = 1'b0;
      waitCycles(3);
      checkOutput("t6_buffer_full", 32'(bus.m_valid), 32'd1);
      rst = 1'b1;
      nextCycle();
      checkOutput("t6_valid_cleared", 32'(bus.m_valid), 32'd0);
      checkOutput("t6_last_cleared", 32'(bus.m_last), 32'(PKT_LEN == 1));
      rst = 1'b0;
      bus.m_ready = 1'b1;
      for (int i = 0; i < 4; i++) pushWord(8'(8'hD0 + i));
      waitCycles(16);

      // Randomized soak
      for (int i = 0; i < 3000; i++) begin
         applyStimulus();
         nextCycle();
      end

      // Drain everything left in the fifo and the buffer
      rst          = 1'b0;
      enable       = 1'b1;
      bus.m_ready  = 1'b1;
      drain_cycles = 0;
      while ((exp_idx != pushed_cnt) && (drain_cycles < 3000)) begin
         nextCycle();
         drain_cycles++;
      end
      nextCycle();
      checkOutput("drain_complete", 32'(exp_idx), 32'(pushed_cnt));
      checkOutput("drain_idle", 32'(bus.m_valid), 32'd0);
      checkOutput("drain_no_rd_en", 32'(bus.fifo_rd_en), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
